mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_lane.sv | 28 ++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states,
// owner tags, access size codes and the timeout read pattern.
package mem_arb_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;

  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
  localparam int          NUM_LANES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/mem_arb_lane.sv
// Byte-lane helper: enables and store replication for the outgoing request,
// plus lane extraction (zero-extended) for the returning read data.
module mem_arb_lane
  import mem_arb_pkg::*;
(
  input  logic        size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  input  logic        rsp_size,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);
  logic [NUM_LANES-1:0][7:0] wlanes;
  logic [NUM_LANES-1:0][7:0] rlanes;

  assign rlanes = rdata_in;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign be[i]     = (size == SZ_BYTE) ? (off == 2'(i)) : 1'b1;
    assign wlanes[i] = (size == SZ_BYTE) ? wdata_in[7:0] : wdata_in[8*i +: 8];
  end

  assign wdata_out = wlanes;
  assign rdata_out = (rsp_size == SZ_BYTE) ? {24'h0, rlanes[rsp_off]} : rdata_in;
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one shared memory port.
// Define ARB_FAIR_EN to add a starvation counter that periodically favours fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic          owner;
  logic          rsp_size;
  logic [1:0]    rsp_off;
  logic [CW-1:0] wait_cnt;
  logic          grant_dm;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;

  mem_arb_lane u_lane (
    .size      (dm_type),
    .off       (dm_addr[1:0]),
    .wdata_in  (dm_wdata),
    .rsp_size  (rsp_size),
    .rsp_off   (rsp_off),
    .rdata_in  (mem_rdata),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  // Once fetch has lost STARVE_MAX contested grants, it takes the next one.
  assign grant_dm = dm_req & ~(if_req & (starve_cnt >= SW'(STARVE_MAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (state == S_IDLE) begin
      if (grant_dm && if_req)
        starve_cnt <= starve_cnt + 1'b1;
      else if (if_req)
        starve_cnt <= '0;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= OWN_IF;
      rsp_size  <= SZ_WORD;
      rsp_off   <= '0;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (grant_dm) begin
            owner <= OWN_DM;
            if (dm_type == SZ_WORD && dm_addr[1:0] != 2'b00) begin
              // Misaligned word: answer immediately without touching memory.
              state    <= S_RESP;
              dm_ready <= 1'b1;
              dm_rdata <= '0;
              err      <= 1'b1;
            end else begin
              state     <= S_WAIT;
              mem_req   <= 1'b1;
              mem_we    <= dm_we;
              mem_be    <= lane_be;
              mem_addr  <= word_align(dm_addr);
              mem_wdata <= lane_wdata;
              rsp_size  <= dm_type;
              rsp_off   <= dm_addr[1:0];
            end
          end else if (if_req) begin
            owner     <= OWN_IF;
            state     <= S_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= word_align(if_addr);
            mem_wdata <= '0;
            rsp_size  <= SZ_WORD;
            rsp_off   <= '0;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (owner == OWN_DM) begin
              dm_ready <= 1'b1;
              dm_rdata <= lane_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            err     <= 1'b1;
            if (owner == OWN_DM) begin
              dm_ready <= 1'b1;
              dm_rdata <= ERR_DATA;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= ERR_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          if_ready <= 1'b0;
          dm_ready <= 1'b0;
          err      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds expected responses,
// a negedge monitor pops them on every ready pulse.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_type, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem, err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(15), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_dm, input logic [31:0] rd, input bit e);
    exp_t x;
    x.is_dm = is_dm; x.rdata = rd; x.err = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!reset && (if_ready || dm_ready)) begin
      if (exp_q.size() == 0)
        check("sb_extra", 32'(if_ready | dm_ready), 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_owner", 32'(dm_ready), 32'(e.is_dm));
        check("sb_rdata", dm_ready ? dm_rdata : if_rdata, e.rdata);
        check("sb_err", 32'(err), 32'(e.err));
        check("sb_one_ready", 32'(if_ready & dm_ready), 32'd0);
      end
    end
  end

  // Wait (bounded) for mem_req, check the request fields, then ack after dly cycles.
  task automatic serve(input string tag, input logic [31:0] a, input logic [3:0] be,
                       input logic we, input logic [31:0] wd, input int dly,
                       input logic [31:0] rd);
    int n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_be"}, 32'(mem_be), 32'(be));
    check({tag, "_we"}, 32'(mem_we), 32'(we));
    if (we) check({tag, "_wdata"}, mem_wdata, wd);
    repeat (dly) @(negedge clk);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_type = 0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Isolated fetch: cycle 1 IDLE, cycle 2 WAIT (ack), cycle 3 ready.
    if_req = 1; if_addr = 32'h100;
    push(0, 32'h12345678, 0);
    @(negedge clk);
    check("f_req", 32'(mem_req), 32'd1);
    check("f_addr", mem_addr, 32'h100);
    check("f_be", 32'(mem_be), 32'hF);
    check("f_stall", 32'(stall_if), 32'd1);
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    check("f_latency_ready", 32'(if_ready), 32'd1);
    check("f_req_drop", 32'(mem_req), 32'd0);
    if_req = 0;
    @(negedge clk);
    check("f_ready_pulse", 32'(if_ready), 32'd0);

    // Stray ack while idle is ignored.
    mem_ack = 1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
    check("stray_ack_req", 32'(mem_req), 32'd0);
    check("stray_ack_ready", 32'({if_ready, dm_ready}), 32'd0);

    // Simultaneous requests: data store first, then fetch.
    dm_req = 1; dm_we = 1; dm_type = 0; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
    if_req = 1; if_addr = 32'h104;
    push(1, 32'h0, 0);
    push(0, 32'hA5A50104, 0);
    serve("sim_dm", 32'h200, 4'hF, 1'b1, 32'hCAFEF00D, 0, 32'h0);
    check("sim_dm_ready", 32'(dm_ready), 32'd1);
    check("sim_if_wait", 32'(if_ready), 32'd0);
    check("sim_stall_if", 32'(stall_if), 32'd1);
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    check("sim_stall_if_idle", 32'(stall_if), 32'd1);
    serve("sim_if", 32'h104, 4'hF, 1'b0, 32'h0, 1, 32'hA5A50104);
    check("sim_if_ready", 32'(if_ready), 32'd1);
    if_req = 0;
    @(negedge clk);

    // Byte load at lane 3, then byte store replication.
    dm_req = 1; dm_we = 0; dm_type = 1; dm_addr = 32'h203;
    push(1, 32'h00000011, 0);
    serve("bl", 32'h200, 4'b1000, 1'b0, 32'h0, 0, 32'h11223344);
    check("bl_ready", 32'(dm_ready), 32'd1);
    dm_req = 0;
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_type = 1; dm_addr = 32'h201; dm_wdata = 32'h000000AB;
    push(1, 32'h0, 0);
    serve("bs", 32'h200, 4'b0010, 1'b1, 32'hABABABAB, 0, 32'h0);
    dm_req = 0; dm_we = 0; dm_type = 0;
    @(negedge clk);

    // Misaligned word load: immediate error response, no memory request.
    dm_req = 1; dm_addr = 32'h202;
    push(1, 32'h0, 1);
    @(negedge clk);
    check("mis_mem_req", 32'(mem_req), 32'd0);
    check("mis_ready", 32'(dm_ready), 32'd1);
    check("mis_err", 32'(err), 32'd1);
    dm_req = 0;
    @(negedge clk);
    check("mis_mem_req2", 32'(mem_req), 32'd0);
    check("mis_err_pulse", 32'(err), 32'd0);

    // Timeout: mem_req held for exactly 15 cycles, then error data.
    if_req = 1; if_addr = 32'h300;
    push(0, 32'hDEADBEEF, 1);
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin n++; @(negedge clk); end
    check("to_cycles", 32'(n), 32'd15);
    check("to_ready", 32'(if_ready), 32'd1);
    check("to_err", 32'(err), 32'd1);
    if_req = 0;
    @(negedge clk);

    // Reset during WAIT: request drops at once and no ready follows.
    dm_req = 1; dm_we = 0; dm_type = 0; dm_addr = 32'h400;
    @(negedge clk);
    check("rw_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1 check("rw_async_drop", 32'(mem_req), 32'd0);
    dm_req = 0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (5) begin @(negedge clk); if (dm_ready || if_ready) n++; end
    check("rw_no_ready", 32'(n), 32'd0);

`ifdef ARB_FAIR_EN
    // Continuous contention: DM, DM, DM, IF repeating.
    dm_req = 1; dm_we = 0; dm_type = 0; dm_addr = 32'h500;
    if_req = 1; if_addr = 32'h600;
    for (int g = 0; g < 8; g++) begin
      if (g % 4 == 3) begin
        push(0, 32'h601, 0);
        serve("fair_if", 32'h600, 4'hF, 1'b0, 32'h0, 0, 32'h601);
      end else begin
        push(1, 32'h501, 0);
        serve("fair_dm", 32'h500, 4'hF, 1'b0, 32'h0, 0, 32'h501);
      end
      @(negedge clk);
    end
    dm_req = 0; if_req = 0;
    repeat (4) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
